// File: rtl/beam_acc_multi_if.sv
// ADC capture stream shared by every channel: one sample strobe plus packed samples (ch0 in LSBs).
interface beam_acc_multi_if #(
    parameter int CH_N  = 4,
    parameter int ADC_W = 14
);
    logic                  adc_valid;
    logic [CH_N*ADC_W-1:0] adc_raw_data;

    modport master (output adc_valid, output adc_raw_data);
    modport slave  (input  adc_valid, input  adc_raw_data);
endinterface

// File: rtl/beam_acc_multi.sv
// Multi-channel beam charge accumulator: per-cycle sums, running totals, sliding-window sums, latched interlock.
// Optional build macro BEAM_ACC_SAT_EN: cycle/total adders saturate and o_acc_ovf reports it.
module beam_acc_multi #(
    parameter int CH_N        = 4,
    parameter int ADC_W       = 14,
    parameter int CYC_W       = 23,
    parameter int TOT_W       = 45,
    parameter int CNT_W       = 22,
    parameter int WIN_DEPTH   = 8,
    parameter int MAX_CYC_LEN = 4096
) (
    input  logic                    i_clk,
    input  logic                    i_fRST,
    input  logic                    i_acc_en,
    input  logic                    i_acc_reset,
    input  logic                    i_beam_cycle_flag,
    beam_acc_multi_if.slave         adc,
    input  logic [TOT_W-1:0]        i_total_threshold,
    input  logic [TOT_W-1:0]        i_win_threshold,
    input  logic                    i_ilk_clear,
    output logic [CH_N*CYC_W-1:0]   o_cycle_acc_data,
    output logic [CH_N*TOT_W-1:0]   o_total_acc_data,
    output logic [CH_N*TOT_W-1:0]   o_win_acc_data,
    output logic [CNT_W-1:0]        o_pulse_cnt,
    output logic [CH_N-1:0]         o_ilk_src,
    output logic                    o_beam_interlock,
    output logic                    o_cycle_timeout,
    output logic                    o_acc_ovf
);
    localparam int PTR_W  = $clog2(WIN_DEPTH);
    localparam int WIN_W  = CYC_W + PTR_W;
    localparam int FILL_W = PTR_W + 1;
    localparam int LEN_W  = $clog2(MAX_CYC_LEN);

    typedef enum logic [2:0] {
        ST_INIT, ST_IDLE, ST_CYCLE_INIT, ST_CYCLE_ACC, ST_CYCLE_CLOSE
    } state_t;

    state_t                 state_reg, state_next;
    logic                   flag_prev_reg;
    logic [CNT_W-1:0]       pulse_cnt_reg;
    logic [LEN_W-1:0]       len_reg;
    logic [PTR_W-1:0]       ptr_reg;
    logic [FILL_W-1:0]      fill_reg;
    logic                   timeout_reg;
    logic                   timeout_hit;
    logic                   clr_acc;
    logic                   win_full;
    logic [CH_N*CYC_W-1:0]  cycle_vec;
    logic [CH_N*CYC_W-1:0]  ring_mem [WIN_DEPTH];
    logic [CH_N*CYC_W-1:0]  ring_rd_reg;
    logic [CH_N-1:0]        ilk_vec;

    assign clr_acc  = i_acc_reset | (state_reg == ST_INIT);
    assign win_full = (fill_reg == FILL_W'(WIN_DEPTH));

    always_ff @(posedge i_clk or negedge i_fRST) begin
        if (!i_fRST) state_reg <= ST_INIT;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next  = state_reg;
        timeout_hit = 1'b0;
        case (state_reg)
            ST_INIT:       if (i_acc_en) state_next = ST_IDLE;
            ST_IDLE:       if (i_beam_cycle_flag && !flag_prev_reg && i_acc_en) state_next = ST_CYCLE_INIT;
            ST_CYCLE_INIT: state_next = ST_CYCLE_ACC;
            ST_CYCLE_ACC: begin
                if (!i_beam_cycle_flag) begin
                    state_next = ST_CYCLE_CLOSE;
                end else if (len_reg == LEN_W'(MAX_CYC_LEN - 1)) begin
                    state_next  = ST_CYCLE_CLOSE;
                    timeout_hit = 1'b1;
                end
            end
            ST_CYCLE_CLOSE: state_next = ST_IDLE;
            default:        state_next = ST_INIT;
        endcase
        if (i_acc_reset) state_next = ST_INIT;
    end

    always_ff @(posedge i_clk or negedge i_fRST) begin
        if (!i_fRST) begin
            flag_prev_reg <= 1'b0;
            pulse_cnt_reg <= '0;
            len_reg       <= '0;
            ptr_reg       <= '0;
            fill_reg      <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            flag_prev_reg <= i_beam_cycle_flag;
            if (clr_acc) begin
                pulse_cnt_reg <= '0;
                len_reg       <= '0;
                ptr_reg       <= '0;
                fill_reg      <= '0;
                timeout_reg   <= 1'b0;
            end else begin
                if (timeout_hit) timeout_reg <= 1'b1;
                case (state_reg)
                    ST_CYCLE_INIT: begin
                        pulse_cnt_reg <= pulse_cnt_reg + CNT_W'(1);
                        len_reg       <= '0;
                    end
                    ST_CYCLE_ACC:  len_reg <= len_reg + LEN_W'(1);
                    ST_CYCLE_CLOSE: begin
                        ptr_reg <= ptr_reg + PTR_W'(1);
                        if (!win_full) fill_reg <= fill_reg + FILL_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Ring read is registered; the pointer is stable through the accumulate phase, so the oldest
    // entry is already in ring_rd_reg by the time CYCLE_CLOSE consumes it.
    always_ff @(posedge i_clk) begin
        if (state_reg == ST_CYCLE_CLOSE && !i_acc_reset) ring_mem[ptr_reg] <= cycle_vec;
        ring_rd_reg <= ring_mem[ptr_reg];
    end

`ifdef BEAM_ACC_SAT_EN
    logic [CH_N-1:0] sat_vec;
    logic            ovf_reg;

    always_ff @(posedge i_clk or negedge i_fRST) begin
        if (!i_fRST)       ovf_reg <= 1'b0;
        else if (clr_acc)  ovf_reg <= 1'b0;
        else if (|sat_vec) ovf_reg <= 1'b1;
    end
    assign o_acc_ovf = ovf_reg;
`else
    assign o_acc_ovf = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < CH_N; gi++) begin : g_ch
            logic [ADC_W-1:0] sample;
            logic [CYC_W-1:0] cycle_reg, cyc_new, win_old;
            logic [TOT_W-1:0] total_reg, tot_new;
            logic [WIN_W-1:0] win_reg, win_new;
            logic             ilk_reg, ilk_cond;

            assign sample = adc.adc_raw_data[gi*ADC_W +: ADC_W];
`ifdef BEAM_ACC_SAT_EN
            logic [CYC_W:0] cyc_wide;
            logic [TOT_W:0] tot_wide;
            assign cyc_wide = {1'b0, cycle_reg} + {{(CYC_W+1-ADC_W){1'b0}}, sample};
            assign tot_wide = {1'b0, total_reg} + {{(TOT_W+1-CYC_W){1'b0}}, cycle_reg};
            assign cyc_new  = cyc_wide[CYC_W] ? {CYC_W{1'b1}} : cyc_wide[CYC_W-1:0];
            assign tot_new  = tot_wide[TOT_W] ? {TOT_W{1'b1}} : tot_wide[TOT_W-1:0];
            assign sat_vec[gi] = (state_reg == ST_CYCLE_ACC && adc.adc_valid && cyc_wide[CYC_W]) ||
                                 (state_reg == ST_CYCLE_CLOSE && tot_wide[TOT_W]);
`else
            assign cyc_new = cycle_reg + CYC_W'(sample);
            assign tot_new = total_reg + TOT_W'(cycle_reg);
`endif
            // Oldest entry leaves the window only once the ring holds WIN_DEPTH valid cycles.
            assign win_old  = win_full ? ring_rd_reg[gi*CYC_W +: CYC_W] : '0;
            assign win_new  = win_reg + WIN_W'(cycle_reg) - WIN_W'(win_old);
            assign ilk_cond = ((i_total_threshold != '0) && (total_reg >= i_total_threshold)) ||
                              ((i_win_threshold   != '0) && (TOT_W'(win_reg) >= i_win_threshold));

            always_ff @(posedge i_clk or negedge i_fRST) begin
                if (!i_fRST) begin
                    cycle_reg <= '0;
                    total_reg <= '0;
                    win_reg   <= '0;
                    ilk_reg   <= 1'b0;
                end else begin
                    ilk_reg <= ilk_cond | (ilk_reg & ~i_ilk_clear);
                    if (clr_acc) begin
                        cycle_reg <= '0;
                        total_reg <= '0;
                        win_reg   <= '0;
                    end else begin
                        case (state_reg)
                            ST_CYCLE_INIT: cycle_reg <= '0;
                            ST_CYCLE_ACC:  if (adc.adc_valid) cycle_reg <= cyc_new;
                            ST_CYCLE_CLOSE: begin
                                total_reg <= tot_new;
                                win_reg   <= win_new;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            assign cycle_vec[gi*CYC_W +: CYC_W]        = cycle_reg;
            assign o_total_acc_data[gi*TOT_W +: TOT_W] = total_reg;
            assign o_win_acc_data[gi*TOT_W +: TOT_W]   = TOT_W'(win_reg);
            assign ilk_vec[gi]                         = ilk_reg;
        end
    endgenerate

    assign o_cycle_acc_data = cycle_vec;
    assign o_pulse_cnt      = pulse_cnt_reg;
    assign o_ilk_src        = ilk_vec;
    assign o_beam_interlock = |ilk_vec;
    assign o_cycle_timeout  = timeout_reg;
endmodule

// File: tb/tb_beam_acc_multi.sv
// Directed bench for beam_acc_multi (CH_N=2, CYC_W=16, WIN_DEPTH=4, MAX_CYC_LEN=16), hand-computed expectations.
module tb_beam_acc_multi;
    localparam int CH_N = 2, ADC_W = 14, CYC_W = 16, TOT_W = 45, CNT_W = 22;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  acc_en, acc_reset, flag, ilk_clear;
    logic [TOT_W-1:0]      thr_tot, thr_win;
    logic [CH_N*CYC_W-1:0] cyc_data;
    logic [CH_N*TOT_W-1:0] tot_data, win_data;
    logic [CNT_W-1:0]      pulse_cnt;
    logic [CH_N-1:0]       ilk_src;
    logic                  beam_ilk, cyc_timeout, acc_ovf;

    int checks = 0;
    int failures = 0;

    beam_acc_multi_if #(.CH_N(CH_N), .ADC_W(ADC_W)) adc_if ();

    beam_acc_multi #(
        .CH_N(CH_N), .ADC_W(ADC_W), .CYC_W(CYC_W), .TOT_W(TOT_W), .CNT_W(CNT_W),
        .WIN_DEPTH(4), .MAX_CYC_LEN(16)
    ) dut (
        .i_clk(clk), .i_fRST(rst_n), .i_acc_en(acc_en), .i_acc_reset(acc_reset),
        .i_beam_cycle_flag(flag), .adc(adc_if.slave),
        .i_total_threshold(thr_tot), .i_win_threshold(thr_win), .i_ilk_clear(ilk_clear),
        .o_cycle_acc_data(cyc_data), .o_total_acc_data(tot_data), .o_win_acc_data(win_data),
        .o_pulse_cnt(pulse_cnt), .o_ilk_src(ilk_src), .o_beam_interlock(beam_ilk),
        .o_cycle_timeout(cyc_timeout), .o_acc_ovf(acc_ovf)
    );

    function automatic logic [63:0] cyc(input int c);
        return 64'(cyc_data[c*CYC_W +: CYC_W]);
    endfunction
    function automatic logic [63:0] tot(input int c);
        return 64'(tot_data[c*TOT_W +: TOT_W]);
    endfunction
    function automatic logic [63:0] win(input int c);
        return 64'(win_data[c*TOT_W +: TOT_W]);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int d0, input int d1);
        adc_if.adc_raw_data = {14'(d1), 14'(d0)};
    endtask

    // IDLE -> CYCLE_INIT -> n accumulating clocks (last one with flag low) -> CYCLE_CLOSE
    task automatic run_cycle(input int d0, input int d1, input int n);
        flag = 1'b1; adc_if.adc_valid = 1'b0;
        tick(); tick();
        adc_if.adc_valid = 1'b1; set_data(d0, d1);
        repeat (n - 1) tick();
        flag = 1'b0;
        tick();
        adc_if.adc_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_acc_reset();
        acc_reset = 1'b1; tick(); acc_reset = 1'b0; tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        acc_en = 0; acc_reset = 0; flag = 0; ilk_clear = 0; thr_tot = '0; thr_win = '0;
        adc_if.adc_valid = 0; adc_if.adc_raw_data = '0;
        #12;
        check("rst_pulse", 64'(pulse_cnt), 0);
        check("rst_cyc0", cyc(0), 0);
        check("rst_tot0", tot(0), 0);
        check("rst_ilk", 64'(ilk_src), 0);
        check("rst_timeout", 64'(cyc_timeout), 0);
        check("rst_ovf", 64'(acc_ovf), 0);
        tick(); rst_n = 1'b1; acc_en = 1'b1;
        tick();

        // Basic cycle
        run_cycle(100, 3, 5);
        $display("basic cycle: cyc={%0d,%0d} tot={%0d,%0d} pulse=%0d", cyc(0), cyc(1), tot(0), tot(1), pulse_cnt);
        check("basic_cyc0", cyc(0), 500);
        check("basic_cyc1", cyc(1), 15);
        check("basic_tot0", tot(0), 500);
        check("basic_tot1", tot(1), 15);
        check("basic_win0", win(0), 500);
        check("basic_pulse", 64'(pulse_cnt), 1);
        tick();
        check("basic_ilk", 64'(ilk_src), 0);
        check("basic_timeout", 64'(cyc_timeout), 0);

        acc_reset = 1'b1; tick(); acc_reset = 1'b0;
        check("accrst_pulse", 64'(pulse_cnt), 0);
        check("accrst_tot0", tot(0), 0);
        check("accrst_cyc0", cyc(0), 0);
        tick();

        // Sliding window
        for (int k = 1; k <= 5; k++) begin
            run_cycle(100 * k, 0, 1);
            $display("window cycle %0d: cyc0=%0d win0=%0d tot0=%0d", k, cyc(0), win(0), tot(0));
            if (k == 4) check("win_after4", win(0), 1000);
        end
        check("win_after5", win(0), 1400);
        check("win_tot0", tot(0), 1500);
        check("win_pulse", 64'(pulse_cnt), 5);
        check("win_ch1", win(1), 0);

        // Timeout with flag held high
        pulse_acc_reset();
        flag = 1'b1; adc_if.adc_valid = 1'b1; set_data(1, 0);
        repeat (40) tick();
        $display("timeout: cyc0=%0d timeout=%0d pulse=%0d", cyc(0), cyc_timeout, pulse_cnt);
        check("to_cyc0", cyc(0), 16);
        check("to_flag", 64'(cyc_timeout), 1);
        check("to_pulse_held", 64'(pulse_cnt), 1);
        check("to_tot0", tot(0), 16);
        flag = 1'b0; adc_if.adc_valid = 1'b0; tick();
        run_cycle(1, 0, 2);
        $display("after timeout: cyc0=%0d pulse=%0d", cyc(0), pulse_cnt);
        check("to_next_cyc0", cyc(0), 2);
        check("to_next_pulse", 64'(pulse_cnt), 2);
        check("to_sticky", 64'(cyc_timeout), 1);

        // Total-threshold interlock
        pulse_acc_reset();
        thr_tot = 45'd1000;
        run_cycle(0, 120, 5); tick();
        check("ilk_first", 64'(ilk_src), 0);
        run_cycle(0, 120, 5);
        check("ilk_tot1", tot(1), 1200);
        check("ilk_not_yet", 64'(ilk_src), 0);
        tick();
        $display("interlock: src=%0d beam=%0d tot1=%0d", ilk_src, beam_ilk, tot(1));
        check("ilk_set", 64'(ilk_src), 2);
        check("ilk_beam", 64'(beam_ilk), 1);
        ilk_clear = 1'b1; tick(); ilk_clear = 1'b0;
        check("ilk_clear_ignored", 64'(ilk_src), 2);
        acc_reset = 1'b1; tick(); acc_reset = 1'b0; tick();
        check("ilk_kept_in_init", 64'(ilk_src), 2);
        ilk_clear = 1'b1; tick(); ilk_clear = 1'b0;
        check("ilk_cleared", 64'(ilk_src), 0);
        check("ilk_beam_cleared", 64'(beam_ilk), 0);

        // Window-threshold interlock
        thr_tot = '0; thr_win = 45'd500;
        run_cycle(120, 0, 5); tick();
        $display("win interlock: win0=%0d src=%0d", win(0), ilk_src);
        check("ilkwin_set", 64'(ilk_src), 1);
        thr_win = '0; ilk_clear = 1'b1; tick(); ilk_clear = 1'b0;
        check("ilkwin_cleared", 64'(ilk_src), 0);
        run_cycle(16000, 16000, 4); tick();
        check("thr0_no_trip", 64'(ilk_src), 0);
        check("thr0_tot0", tot(0), 64000 + 600);

        // Saturation / wrap
        pulse_acc_reset();
        run_cycle(16383, 0, 5);
        $display("saturation: cyc0=%0d tot0=%0d ovf=%0d", cyc(0), tot(0), acc_ovf);
`ifdef BEAM_ACC_SAT_EN
        check("sat_cyc0", cyc(0), 65535);
        check("sat_tot0", tot(0), 65535);
        check("sat_ovf", 64'(acc_ovf), 1);
`else
        check("wrap_cyc0", cyc(0), 16379);
        check("wrap_tot0", tot(0), 16379);
        check("wrap_ovf", 64'(acc_ovf), 0);
`endif
        pulse_acc_reset();
        check("ovf_cleared", 64'(acc_ovf), 0);

        // Async reset mid-cycle
        flag = 1'b1; adc_if.adc_valid = 1'b1; set_data(7, 9);
        tick(); tick(); tick();
        check("mid_cyc0", cyc(0), 7);
        check("mid_pulse", 64'(pulse_cnt), 1);
        rst_n = 1'b0; #1;
        $display("async reset: cyc0=%0d cyc1=%0d pulse=%0d", cyc(0), cyc(1), pulse_cnt);
        check("arst_cyc0", cyc(0), 0);
        check("arst_cyc1", cyc(1), 0);
        check("arst_pulse", 64'(pulse_cnt), 0);
        flag = 1'b0; adc_if.adc_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();

        // Synchronous acc_reset mid-cycle
        flag = 1'b1; adc_if.adc_valid = 1'b1; set_data(5, 5);
        tick(); tick(); tick();
        check("mid2_pulse", 64'(pulse_cnt), 1);
        acc_reset = 1'b1; tick(); acc_reset = 1'b0;
        check("srst_pulse", 64'(pulse_cnt), 0);
        check("srst_cyc0", cyc(0), 0);
        flag = 1'b0; adc_if.adc_valid = 1'b0; tick();
        run_cycle(2, 3, 3);
        $display("restart: cyc={%0d,%0d} pulse=%0d", cyc(0), cyc(1), pulse_cnt);
        check("restart_cyc0", cyc(0), 6);
        check("restart_cyc1", cyc(1), 9);
        check("restart_pulse", 64'(pulse_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
